// File: rtl/mvp_pkg.sv
// mvp_pkg: shared types and helpers for the sequential MVP builder.
//   mat4_t    - 4x4 matrix of Q8.8 elements, row-major, element r*4+c
//   state_t   - sequencer state encoding
//   sat16     - clamps a wide signed value into the 16-bit signed range
package mvp_pkg;

   localparam int FRAC_BITS = 8;
   localparam int WIDTH     = 16;
   localparam int ACC_WIDTH = 34;

   typedef logic [15:0][15:0] mat4_t;

   typedef enum logic [1:0] {
      IDLE,
      PASS1,
      PASS2,
      DONE
   } state_t;

   function automatic logic [15:0] sat16(input logic signed [ACC_WIDTH-1:0] v);
      logic signed [ACC_WIDTH-1:0] sat_max;
      logic signed [ACC_WIDTH-1:0] sat_min;
      sat_max = 34'sd32767;
      sat_min = -34'sd32768;
      if (v > sat_max)
         return 16'h7FFF;
      else if (v < sat_min)
         return 16'h8000;
      else
         return v[15:0];
   endfunction

endpackage

// File: rtl/mvp_sequencer_mac.sv
// mac_q88: the single shared multiply-accumulate unit.
//   Clk, Reset - clock, asynchronous active-high reset
//   en         - accumulate this cycle
//   clear      - start a new element (accumulator treated as zero)
//   a, b       - signed Q8.8 operands
//   result     - saturated (acc_next >>> FRAC), i.e. the element value that
//                includes this cycle's product
module mac_q88
   import mvp_pkg::*;
#(
   parameter int FRAC = 8
)(
   input  logic               Clk,
   input  logic               Reset,
   input  logic               en,
   input  logic               clear,
   input  logic signed [15:0] a,
   input  logic signed [15:0] b,
   output logic        [15:0] result
);

   logic signed [31:0]          product;
   logic signed [ACC_WIDTH-1:0] acc;
   logic signed [ACC_WIDTH-1:0] acc_next;
   logic signed [ACC_WIDTH-1:0] shifted;

   always_comb begin
      product  = a * b;
      acc_next = (clear ? '0 : acc) + {{(ACC_WIDTH-32){product[31]}}, product};
      shifted  = acc_next >>> FRAC;
      result   = sat16(shifted);
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)
         acc <= '0;
      else if (en)
         acc <= acc_next;
   end

endmodule

// File: rtl/mvp_sequencer.sv
// mvp_sequencer: computes mvp = projection x view x model with one MAC.
//   Clk, Reset         - clock, asynchronous active-high reset
//   start              - begin a computation (sampled only in IDLE)
//   model/view/projection_matrix - row-major Q8.8 inputs, latched on start
//   busy               - high from the start edge until back in IDLE
//   done               - one-cycle pulse, mvp_matrix is new
//   mvp_matrix         - registered result, held until the next done
module mvp_sequencer #(
   parameter int FRAC_BITS = 8,
   parameter int WIDTH     = 16
)(
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   start,
   input  logic [15:0][WIDTH-1:0] model_matrix,
   input  logic [15:0][WIDTH-1:0] view_matrix,
   input  logic [15:0][WIDTH-1:0] projection_matrix,
   output logic                   busy,
   output logic                   done,
   output logic [15:0][WIDTH-1:0] mvp_matrix
);

   import mvp_pkg::*;

   state_t state, state_next;

   mat4_t model_l, view_l, proj_l;
   mat4_t t_buf, r_buf;

   logic [1:0]  r, c, k;
   logic        last;
   logic        mac_en;
   logic        mac_clear;
   logic [15:0] op_a, op_b;
   logic [15:0] mac_result;

   // state register
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   // next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = PASS1;
         PASS1:   if (last)  state_next = PASS2;
         PASS2:   if (last)  state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // outputs and datapath controls
   always_comb begin
      busy      = (state != IDLE);
      done      = (state == DONE);
      mac_en    = (state == PASS1) || (state == PASS2);
      mac_clear = (k == 2'd0);
      last      = (r == 2'd3) && (c == 2'd3) && (k == 2'd3);
   end

   // PASS1: A = view, B = model.  PASS2: A = projection, B = T.
   always_comb begin
      if (state == PASS1) begin
         op_a = view_l[{r, k}];
         op_b = model_l[{k, c}];
      end else begin
         op_a = proj_l[{r, k}];
         op_b = t_buf[{k, c}];
      end
   end

   mac_q88 #(
      .FRAC (FRAC_BITS)
   ) u_mac (
      .Clk    (Clk),
      .Reset  (Reset),
      .en     (mac_en),
      .clear  (mac_clear),
      .a      (op_a),
      .b      (op_b),
      .result (mac_result)
   );

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         model_l    <= '0;
         view_l     <= '0;
         proj_l     <= '0;
         t_buf      <= '0;
         r_buf      <= '0;
         mvp_matrix <= '0;
         r          <= '0;
         c          <= '0;
         k          <= '0;
      end else begin
         if ((state == IDLE) && start) begin
            model_l <= model_matrix;
            view_l  <= view_matrix;
            proj_l  <= projection_matrix;
         end
         // 2-bit counters wrap to zero at the end of each pass
         if (mac_en) begin
            k <= k + 2'd1;
            if (k == 2'd3) begin
               c <= c + 2'd1;
               if (c == 2'd3)
                  r <= r + 2'd1;
               if (state == PASS1)
                  t_buf[{r, c}] <= mac_result;
               else
                  r_buf[{r, c}] <= mac_result;
            end
         end
         // element 15 is written on this same edge, so take it from the MAC
         if ((state == PASS2) && last) begin
            mvp_matrix     <= r_buf;
            mvp_matrix[15] <= mac_result;
         end
      end
   end

endmodule

// File: tb/tb_mvp_sequencer.sv
module tb_mvp_sequencer;

   import mvp_pkg::*;

   logic  Clk = 1'b0;
   logic  Reset;
   logic  start;
   mat4_t model_m, view_m, proj_m, mvp;
   logic  busy, done;

   int    checks = 0;
   int    errors = 0;
   mat4_t exp_q[$];

   always #5 Clk = ~Clk;

   mvp_sequencer #(
      .FRAC_BITS (8),
      .WIDTH     (16)
   ) dut (
      .Clk               (Clk),
      .Reset             (Reset),
      .start             (start),
      .model_matrix      (model_m),
      .view_matrix       (view_m),
      .projection_matrix (proj_m),
      .busy              (busy),
      .done              (done),
      .mvp_matrix        (mvp)
   );

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic mat4_t diag(input logic [15:0] d0, d1, d2, d3);
      mat4_t o;
      o = '0;
      o[0] = d0; o[5] = d1; o[10] = d2; o[15] = d3;
      return o;
   endfunction

   // reference product with floor shift and saturation
   function automatic mat4_t mm(input mat4_t a, input mat4_t b);
      mat4_t o;
      longint s;
      logic signed [15:0] x, y;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            s = 0;
            for (int k = 0; k < 4; k++) begin
               x = a[r*4+k];
               y = b[k*4+c];
               s += longint'(x) * longint'(y);
            end
            s = s >>> 8;
            if (s > 32767)       o[r*4+c] = 16'h7FFF;
            else if (s < -32768) o[r*4+c] = 16'h8000;
            else                 o[r*4+c] = s[15:0];
         end
      return o;
   endfunction

   function automatic mat4_t rnd_small();
      mat4_t o;
      for (int i = 0; i < 16; i++)
         o[i] = 16'($urandom_range(0, 1536)) - 16'd768;
      return o;
   endfunction

   function automatic mat4_t rnd_full();
      mat4_t o;
      for (int i = 0; i < 16; i++)
         o[i] = 16'($urandom);
      return o;
   endfunction

   // pulse start; t0 is the time just after the accepting edge E0
   task automatic start_op(output time t0);
      @(posedge Clk); #1;
      start = 1'b1;
      @(posedge Clk); #1;
      start = 1'b0;
      t0 = $time;
   endtask

   // wait for done, check latency and result, then check the done/idle edge
   task automatic finish_op(input time t0, input string tag);
      int    lat;
      mat4_t expv;
      lat = -1;
      repeat (300) begin
         @(posedge Clk); #1;
         if (done) begin
            lat = int'(($time - t0) / 10);
            break;
         end
      end
      check({tag, "_latency"}, 256'(lat), 256'(128));
      if (exp_q.size() == 0) begin
         check({tag, "_scoreboard_empty"}, 256'(1), 256'(0));
      end else begin
         expv = exp_q.pop_front();
         check({tag, "_mvp"}, mvp, expv);
      end
      // a start sampled on the DONE->IDLE edge must be ignored
      start = 1'b1;
      @(posedge Clk); #1;
      start = 1'b0;
      check({tag, "_done_drop"}, 256'({busy, done}), 256'(0));
   endtask

   task automatic run_case(input string tag, input mat4_t m, v, p, input mat4_t expv);
      time t0;
      model_m = m; view_m = v; proj_m = p;
      exp_q.push_back(expv);
      start_op(t0);
      check({tag, "_busy"}, 256'(busy), 256'(1));
      finish_op(t0, tag);
   endtask

   initial begin : stim
      mat4_t ident, m, v, p, e;
      time   t0;
      int    ndone, first_t, prev_t, cur_t;

      ident = diag(16'h0100, 16'h0100, 16'h0100, 16'h0100);
      Reset = 1'b1; start = 1'b0;
      model_m = '0; view_m = '0; proj_m = '0;
      #1;
      check("reset_busy", 256'(busy), 256'(0));
      check("reset_done", 256'(done), 256'(0));
      check("reset_mvp", mvp, 256'(0));
      repeat (3) @(posedge Clk);
      @(negedge Clk) Reset = 1'b0;

      run_case("identity", ident, ident, ident, ident);

      m = diag(16'h0200, 16'h0200, 16'h0200, 16'h0100);
      v = ident; v[3] = 16'h0100;
      e = diag(16'h0200, 16'h0200, 16'h0200, 16'h0100); e[3] = 16'h0100;
      run_case("scale_translate", m, v, ident, e);

      m = diag(16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00);
      run_case("sat_pos", m, diag(16'h0200, 16'h0200, 16'h0200, 16'h0200), ident,
               diag(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF));
      run_case("sat_neg", m, diag(16'hFE00, 16'hFE00, 16'hFE00, 16'hFE00), ident,
               diag(16'h8000, 16'h8000, 16'h8000, 16'h8000));

      m = ident; m[0] = 16'h0080;
      v = ident; v[0] = 16'h0001;
      e = ident; e[0] = 16'h0000;
      run_case("trunc_zero", m, v, ident, e);
      v[0] = 16'hFFFF;
      e[0] = 16'hFFFF;
      run_case("trunc_floor", m, v, ident, e);

      m = rnd_small(); v = rnd_small(); p = rnd_small();
      run_case("random_small", m, v, p, mm(p, mm(v, m)));

      // inputs change mid-run; result must follow the latched values
      m = rnd_full(); v = rnd_small(); p = rnd_small();
      model_m = m; view_m = v; proj_m = p;
      exp_q.push_back(mm(p, mm(v, m)));
      start_op(t0);
      repeat (10) @(posedge Clk);
      #1;
      model_m = rnd_full(); view_m = rnd_full(); proj_m = rnd_full();
      finish_op(t0, "input_change");

      // reset during PASS2 (mvp currently holds the previous non-zero result)
      model_m = ident; view_m = ident; proj_m = ident;
      start_op(t0);
      repeat (80) @(posedge Clk);
      #2 Reset = 1'b1;
      #1;
      check("midreset_busy", 256'(busy), 256'(0));
      check("midreset_done", 256'(done), 256'(0));
      check("midreset_mvp", mvp, 256'(0));
      @(negedge Clk) Reset = 1'b0;
      m = diag(16'h0200, 16'h0200, 16'h0200, 16'h0100);
      v = ident; v[3] = 16'h0100;
      e = diag(16'h0200, 16'h0200, 16'h0200, 16'h0100); e[3] = 16'h0100;
      run_case("after_reset", m, v, ident, e);

      // start held high: one done every 130 cycles, first at 128
      m = rnd_small(); v = rnd_small(); p = rnd_small();
      model_m = m; view_m = v; proj_m = p;
      repeat (3) exp_q.push_back(mm(p, mm(v, m)));
      @(posedge Clk); #1;
      start = 1'b1;
      @(posedge Clk); #1;
      t0 = $time;
      ndone = 0; first_t = -1; prev_t = 0;
      for (int i = 1; i <= 400; i++) begin
         @(posedge Clk); #1;
         if (done) begin
            cur_t = int'(($time - t0) / 10);
            if (ndone == 0) first_t = cur_t;
            else check("held_interval", 256'(cur_t - prev_t), 256'(130));
            prev_t = cur_t;
            ndone++;
            if (exp_q.size() != 0) check("held_mvp", mvp, exp_q.pop_front());
         end
      end
      start = 1'b0;
      check("held_first_latency", 256'(first_t), 256'(128));
      check("held_done_count", 256'(ndone), 256'(3));
      check("held_queue_drained", 256'(exp_q.size()), 256'(0));
      @(negedge Clk) Reset = 1'b1;
      @(negedge Clk) Reset = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
